fc_init_responder: RTL
======================

Name: fc_init_responder

Overview:
- Fuse-controller-side responder to the boot sequencer's OTP init handshake.
- On the level `fc_opt_init` request it walks every OTP partition word-by-word over a single-outstanding read port and checks each partition's XOR digest.
- It then raises a sticky `fc_opt_done`, which the boot sequencer synchronises before advancing to LCC.
- Read or integrity failures are reported through `fc_opt_err`, `err_part` and per-partition valid bits.

Parameters:
- NUM_PARTS, 4: number of contiguous partitions; partition p starts at word p*PART_WORDS.
- PART_WORDS, 16: words per partition including the final digest word; minimum 2.
- DATA_W, 32: OTP word width.
- ADDR_W, 8: word address width; must satisfy NUM_PARTS*PART_WORDS <= 2**ADDR_W.
- TIMEOUT_W, 6: read-data timeout counter width; timeout fires at count 2**TIMEOUT_W-1.

Ports:
- clk  in  1  block clock.
- rst  in  1  synchronous active-high reset.
- fc_opt_init  in  1  init request level from boot sequencer, already in clk domain.
- fc_opt_done  out  1  sticky init-complete, high on success or error.
- fc_opt_err  out  1  sticky, an error terminated the walk.
- err_part  out  $clog2(NUM_PARTS) (min 1)  index of failing partition, valid when fc_opt_err.
- part_valid  out  NUM_PARTS  bit p set when partition p digest matched.
- otp_req  out  1  read request, held until otp_gnt.
- otp_addr  out  ADDR_W  word address, stable while otp_req.
- otp_gnt  in  1  request accepted this cycle.
- otp_rvalid  in  1  read data valid.
- otp_rdata  in  DATA_W  read data.
- otp_rerr  in  1  uncorrectable read error, qualified by otp_rvalid.

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; all outputs 0; counters and accumulator 0.
- Reset mid-walk aborts immediately; the next walk restarts at partition 0.
- IDLE: when fc_opt_init=1, go to REQ with word_idx=0, part_idx=0, acc=0. fc_opt_init=0 stays in IDLE.
- fc_opt_init is sampled only in IDLE. Deassertion mid-walk or after DONE is ignored.
- REQ: otp_req=1, otp_addr=part_idx*PART_WORDS+word_idx. On otp_gnt go to WAIT next cycle; otp_req drops in that cycle. Never more than one read outstanding.
- WAIT: the timeout counter increments each cycle without otp_rvalid.
- WAIT, otp_rvalid with otp_rerr=1: go to ERR (err_part=part_idx).
- WAIT, timeout reached with no rvalid: go to ERR.
- WAIT, otp_rvalid on a non-digest word: acc ^= otp_rdata, word_idx++, back to REQ.
- WAIT, otp_rvalid on the digest word (word_idx=PART_WORDS-1): go to CHECK with the digest captured.
- rvalid arriving in the same cycle as the timeout terminal count is accepted as data, not a timeout.
- Timeout counter clears on every entry to WAIT.
- CHECK (1 cycle): if acc==digest, set part_valid[part_idx].
  - If part_idx==NUM_PARTS-1, go to DONE.
  - Otherwise part_idx++, word_idx=0, acc=0, back to REQ.
  - On mismatch go to ERR.
- ERR (1 cycle): fc_opt_err=1, err_part latched, go to DONE. part_valid bits of earlier partitions are retained.
- DONE: fc_opt_done=1; terminal until rst. Any otp_gnt or otp_rvalid here is ignored.
- Latency with gnt in the same cycle as req and rvalid one cycle later: 2 cycles per word, +1 per partition for CHECK, +1 from IDLE.
  - Minimum cycles from init sampled to done high = 1 + NUM_PARTS*(2*PART_WORDS+1) + 1.
  - Defaults give 134.
- Stray otp_rvalid in REQ or IDLE is ignored, with no state change.

Decomposition:
- mci_pkg gets `fc_init_state_e` {FC_INIT_IDLE, FC_INIT_REQ, FC_INIT_WAIT, FC_INIT_CHECK, FC_INIT_ERR, FC_INIT_DONE, FC_INIT_UNKNOWN}.
  - Default case drives FC_INIT_UNKNOWN.
- One sub-module, fc_init_rd_timer: a TIMEOUT_W counter with clear/enable inputs and a terminal-count output, shared with future OTP clients.

Test Plan:
- Clean walk: NUM_PARTS=4, PART_WORDS=16, each digest = XOR of 15 data words, gnt same cycle, rvalid next cycle -> fc_opt_done rises exactly 134 cycles after init; part_valid=4'hF; fc_opt_err=0; 64 reads at addresses 0..63 in order.
- Digest mismatch: partition 2 digest flipped bit 0 -> part_valid=4'b0011, fc_opt_err=1, err_part=2, fc_opt_done=1, no read issued to address 48.
- Read error and timeout:
  - otp_rerr=1 on address 5 -> err_part=0, part_valid=0, done=1.
  - Separate run, rvalid withheld on address 20 -> ERR 63 cycles after entering WAIT, err_part=1.
- Backpressure and boundary: gnt delayed 3 cycles per request -> otp_addr stable while req high, single outstanding read, same final results.
  - rvalid exactly at timeout terminal count -> accepted, no error.
- Init and reset handling:
  - fc_opt_init dropped at word 10 -> walk completes with done=1.
  - rst pulsed mid-walk at address 30 -> all outputs 0 next cycle.
  - Reassert init after reset -> walk restarts at address 0.

Source files
------------

// File: rtl/mci_pkg.sv
// ---------------------------------------------------------------------------
// mci_pkg
// Shared types and helpers for the fuse-controller init responder.
//   fc_init_state_e : responder FSM states
//   fc_idx_w()      : index width for a count of items, never below 1 bit
// ---------------------------------------------------------------------------
package mci_pkg;

  typedef enum logic [2:0] {
    FC_INIT_IDLE    = 3'd0,
    FC_INIT_REQ     = 3'd1,
    FC_INIT_WAIT    = 3'd2,
    FC_INIT_CHECK   = 3'd3,
    FC_INIT_ERR     = 3'd4,
    FC_INIT_DONE    = 3'd5,
    FC_INIT_UNKNOWN = 3'd6
  } fc_init_state_e;

  // Width of an index over n items; a single item still gets a 1-bit index.
  function automatic int unsigned fc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_init_rd_timer.sv
// ---------------------------------------------------------------------------
// fc_init_rd_timer
// Read-data timeout counter for OTP clients.
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : clear count to zero (wins over i_en)
//   i_en      : increment count this cycle
//   o_tc      : terminal count, high while count == 2**TIMEOUT_W-1
// ---------------------------------------------------------------------------
module fc_init_rd_timer #(
  parameter int unsigned TIMEOUT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

  assign o_tc = &r_count;

endmodule

// File: rtl/fc_init_responder.sv
// ---------------------------------------------------------------------------
// fc_init_responder
// Answers the boot sequencer's OTP init request: reads every OTP partition
// word by word (one read outstanding at most), checks each partition's XOR
// digest (last word of the partition), then raises a sticky done.
//   clk, rst               : clock, synchronous active-high reset
//   fc_opt_init            : init request level (sampled only in IDLE)
//   fc_opt_done            : sticky, walk finished (success or error)
//   fc_opt_err             : sticky, walk terminated by an error
//   err_part               : failing partition index, valid with fc_opt_err
//   part_valid             : bit p set when partition p digest matched
//   otp_req/otp_addr       : read request, held with stable address until gnt
//   otp_gnt                : request accepted this cycle
//   otp_rvalid/otp_rdata   : read data return
//   otp_rerr               : uncorrectable read error, qualified by rvalid
// ---------------------------------------------------------------------------
module fc_init_responder
  import mci_pkg::*;
#(
  parameter int unsigned NUM_PARTS  = 4,
  parameter int unsigned PART_WORDS = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TIMEOUT_W  = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fc_opt_init,
  output logic                              fc_opt_done,
  output logic                              fc_opt_err,
  output logic [fc_idx_w(NUM_PARTS)-1:0]    err_part,
  output logic [NUM_PARTS-1:0]              part_valid,
  output logic                              otp_req,
  output logic [ADDR_W-1:0]                 otp_addr,
  input  logic                              otp_gnt,
  input  logic                              otp_rvalid,
  input  logic [DATA_W-1:0]                 otp_rdata,
  input  logic                              otp_rerr
);

  localparam int unsigned PART_IW = fc_idx_w(NUM_PARTS);
  localparam int unsigned WORD_IW = fc_idx_w(PART_WORDS);
  localparam logic [WORD_IW-1:0] LAST_WORD = WORD_IW'(PART_WORDS - 1);
  localparam logic [PART_IW-1:0] LAST_PART = PART_IW'(NUM_PARTS - 1);

  fc_init_state_e        r_state, w_state_next;
  logic [WORD_IW-1:0]    r_word_idx, w_word_idx_next;
  logic [PART_IW-1:0]    r_part_idx, w_part_idx_next;
  logic [DATA_W-1:0]     r_acc, w_acc_next;
  logic [DATA_W-1:0]     r_digest, w_digest_next;
  logic [NUM_PARTS-1:0]  r_part_valid, w_part_valid_next;
  logic [PART_IW-1:0]    r_err_part, w_err_part_next;
  logic                  r_err, w_err_next;
  logic                  r_done, w_done_next;

  logic                  w_tmr_clr;
  logic                  w_tmr_en;
  logic                  w_tmr_tc;
  logic [ADDR_W-1:0]     w_addr;

  // The timer is held clear for every REQ cycle, so it is zero on each entry
  // to WAIT and counts only the cycles spent waiting for read data.
  fc_init_rd_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_rd_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc  (w_tmr_tc)
  );

  // Indices only change outside REQ, so the address is stable while requesting.
  assign w_addr = ADDR_W'(r_part_idx) * ADDR_W'(PART_WORDS) + ADDR_W'(r_word_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FC_INIT_IDLE;
      r_word_idx   <= '0;
      r_part_idx   <= '0;
      r_acc        <= '0;
      r_digest     <= '0;
      r_part_valid <= '0;
      r_err_part   <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_word_idx   <= w_word_idx_next;
      r_part_idx   <= w_part_idx_next;
      r_acc        <= w_acc_next;
      r_digest     <= w_digest_next;
      r_part_valid <= w_part_valid_next;
      r_err_part   <= w_err_part_next;
      r_err        <= w_err_next;
      r_done       <= w_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_word_idx_next   = r_word_idx;
    w_part_idx_next   = r_part_idx;
    w_acc_next        = r_acc;
    w_digest_next     = r_digest;
    w_part_valid_next = r_part_valid;
    w_err_part_next   = r_err_part;
    w_err_next        = r_err;
    w_done_next       = r_done;
    w_tmr_clr         = 1'b0;
    w_tmr_en          = 1'b0;

    case (r_state)
      FC_INIT_IDLE: begin
        if (fc_opt_init) begin
          w_state_next    = FC_INIT_REQ;
          w_word_idx_next = '0;
          w_part_idx_next = '0;
          w_acc_next      = '0;
        end
      end

      FC_INIT_REQ: begin
        w_tmr_clr = 1'b1;
        if (otp_gnt) begin
          w_state_next = FC_INIT_WAIT;
        end
      end

      FC_INIT_WAIT: begin
        // Data takes priority over the timeout, so a return on the terminal
        // count cycle is still accepted.
        if (otp_rvalid) begin
          if (otp_rerr) begin
            w_state_next = FC_INIT_ERR;
          end else if (r_word_idx == LAST_WORD) begin
            w_digest_next = otp_rdata;
            w_state_next  = FC_INIT_CHECK;
          end else begin
            w_acc_next      = r_acc ^ otp_rdata;
            w_word_idx_next = r_word_idx + WORD_IW'(1);
            w_state_next    = FC_INIT_REQ;
          end
        end else begin
          w_tmr_en = 1'b1;
          if (w_tmr_tc) begin
            w_state_next = FC_INIT_ERR;
          end
        end
      end

      FC_INIT_CHECK: begin
        if (r_acc == r_digest) begin
          w_part_valid_next[r_part_idx] = 1'b1;
          if (r_part_idx == LAST_PART) begin
            w_state_next = FC_INIT_DONE;
          end else begin
            w_part_idx_next = r_part_idx + PART_IW'(1);
            w_word_idx_next = '0;
            w_acc_next      = '0;
            w_state_next    = FC_INIT_REQ;
          end
        end else begin
          w_state_next = FC_INIT_ERR;
        end
      end

      FC_INIT_ERR: begin
        w_err_next      = 1'b1;
        w_err_part_next = r_part_idx;
        w_state_next    = FC_INIT_DONE;
      end

      FC_INIT_DONE: begin
        // Terminal until reset; late grants or read data are ignored.
        w_done_next = 1'b1;
      end

      default: begin
        w_state_next = FC_INIT_UNKNOWN;
      end
    endcase
  end

  assign fc_opt_done = r_done;
  assign fc_opt_err  = r_err;
  assign err_part    = r_err_part;
  assign part_valid  = r_part_valid;
  assign otp_req     = (r_state == FC_INIT_REQ);
  assign otp_addr    = w_addr;

endmodule
